// File: rtl/useq_pkg.sv
// Shared types and constants for the microsequencer: micro-word layout, branch conditions,
// FSM state codes and ALU operation codes.
package useq_pkg;

    localparam int unsigned CTRL_W       = 18;
    localparam int unsigned UADDR_W_DFLT = 6;

    typedef enum logic [2:0] {
        CondSeq  = 3'd0,
        CondJmp  = 3'd1,
        CondJz   = 3'd2,
        CondJnz  = 3'd3,
        CondJn   = 3'd4,
        CondJc   = 3'd5,
        CondRsv  = 3'd6,
        CondHalt = 3'd7
    } cond_e;

    typedef logic [1:0] state_e;
    localparam state_e StIdle = 2'd0;
    localparam state_e StRun  = 2'd1;
    localparam state_e StDone = 2'd2;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluInc = 2'b10;

    // Low CTRL_W bits of every micro-word, independent of the address width.
    typedef struct packed {
        cond_e      cond;
        logic [1:0] alu_op;
        logic       ld_r_out;
        logic       ld_r_in;
        logic       sel_r_in;
        logic       ld_rf;
        logic [2:0] fld_c;
        logic [2:0] fld_b;
        logic [2:0] fld_a;
    } uctrl_t;

    typedef struct packed {
        logic [UADDR_W_DFLT-1:0] next;
        uctrl_t                  ctrl;
    } uword_t;

    // Power-up store content: HALT with every enable clear.
    function automatic logic [CTRL_W-1:0] halt_ctrl();
        uctrl_t c;
        c      = '0;
        c.cond = CondHalt;
        return c;
    endfunction

endpackage

// File: rtl/ucode_store.sv
// Writable micro-store: one synchronous write port, one asynchronous read port.
// Contents are never reset; simulation starts with every word set to INIT.
module ucode_store #(
    parameter int unsigned  AW   = 6,
    parameter int unsigned  DW   = 24,
    parameter logic [DW-1:0] INIT = '0
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0] mem_q [Depth] = '{default: INIT};

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/microsequencer.sv
// Microprogrammed control unit: fetches store[upc], drives its control fields during RUN,
// sequences upc on the registered datapath flags and aborts runaway programs via a watchdog.
module microsequencer
    import useq_pkg::*;
#(
    parameter int unsigned UADDR_W    = UADDR_W_DFLT,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned WDOG_MAX   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    input  logic                      uc_we_i,
    input  logic [UADDR_W-1:0]        uc_waddr_i,
    input  logic [CTRL_W+UADDR_W-1:0] uc_wdata_i,
    input  logic                      cy_i,
    input  logic                      neg_i,
    input  logic                      zero_i,
    output logic [2:0]                fld_a_o,
    output logic [2:0]                fld_b_o,
    output logic [2:0]                fld_c_o,
    output logic                      ld_rf_o,
    output logic                      sel_r_in_o,
    output logic                      ld_r_in_o,
    output logic                      ld_r_out_o,
    output logic [1:0]                alu_op_o,
    output logic [UADDR_W-1:0]        upc_o
);

    localparam int unsigned UW = CTRL_W + UADDR_W;

    state_e             state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic               err_q, err_d;
    logic [31:0]        step_q, step_d;

    logic [UW-1:0]      word;
    uctrl_t             ctrl;
    logic [UADDR_W-1:0] next_addr, upc_inc, upc_next;
    logic               run, wdog_hit;

    ucode_store #(
        .AW   (UADDR_W),
        .DW   (UW),
        .INIT (UW'(halt_ctrl()))
    ) u_store (
        .clk_i   (clk_i),
        .we_i    (uc_we_i && (state_q == StIdle)),
        .waddr_i (uc_waddr_i),
        .wdata_i (uc_wdata_i),
        .raddr_i (upc_q),
        .rdata_o (word)
    );

    assign ctrl      = uctrl_t'(word[CTRL_W-1:0]);
    assign next_addr = word[UW-1:CTRL_W];
    assign upc_inc   = upc_q + 1'b1;
    assign run       = (state_q == StRun);
    // step_q counts RUN cycles already completed, so this fires on the WDOG_MAX-th one.
    assign wdog_hit  = (WDOG_MAX != 0) && ((step_q + 32'd1) == 32'(WDOG_MAX));

    always_comb begin
        upc_next = upc_inc;
        case (ctrl.cond)
            CondJmp: upc_next = next_addr;
            CondJz:  upc_next = zero_i  ? next_addr : upc_inc;
            CondJnz: upc_next = !zero_i ? next_addr : upc_inc;
            CondJn:  upc_next = neg_i   ? next_addr : upc_inc;
            CondJc:  upc_next = cy_i    ? next_addr : upc_inc;
            default: upc_next = upc_inc;
        endcase
    end

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        err_d   = err_q;
        step_d  = step_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    upc_d   = UADDR_W'(START_ADDR);
                    err_d   = 1'b0;
                    step_d  = '0;
                end
            end
            StRun: begin
                step_d = step_q + 32'd1;
                if (ctrl.cond == CondHalt) begin
                    state_d = StDone;
                end else if (wdog_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    upc_d = upc_next;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            upc_q   <= '0;
            err_q   <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            err_q   <= err_d;
            step_q  <= step_d;
        end
    end

    assign busy_o     = run;
    assign done_o     = (state_q == StDone);
    assign err_o      = err_q;
    assign upc_o      = upc_q;
    assign fld_a_o    = run ? ctrl.fld_a    : 3'd0;
    assign fld_b_o    = run ? ctrl.fld_b    : 3'd0;
    assign fld_c_o    = run ? ctrl.fld_c    : 3'd0;
    assign ld_rf_o    = run & ctrl.ld_rf;
    assign sel_r_in_o = run & ctrl.sel_r_in;
    assign ld_r_in_o  = run & ctrl.ld_r_in;
    assign ld_r_out_o = run & ctrl.ld_r_out;
    assign alu_op_o   = run ? ctrl.alu_op   : 2'b00;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares whenever busy or done is presented.
module tb_microsequencer;
    import useq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, uc_we, cy, neg, zero;
    logic [5:0]  uc_waddr;
    logic [23:0] uc_wdata;
    logic        busy, done, err;
    logic [2:0]  fld_a, fld_b, fld_c;
    logic        ld_rf, sel_r_in, ld_r_in, ld_r_out;
    logic [1:0]  alu_op;
    logic [5:0]  upc;

    microsequencer #(
        .UADDR_W    (6),
        .START_ADDR (0),
        .WDOG_MAX   (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .uc_we_i    (uc_we),
        .uc_waddr_i (uc_waddr),
        .uc_wdata_i (uc_wdata),
        .cy_i       (cy),
        .neg_i      (neg),
        .zero_i     (zero),
        .fld_a_o    (fld_a),
        .fld_b_o    (fld_b),
        .fld_c_o    (fld_c),
        .ld_rf_o    (ld_rf),
        .sel_r_in_o (sel_r_in),
        .ld_r_in_o  (ld_r_in),
        .ld_r_out_o (ld_r_out),
        .alu_op_o   (alu_op),
        .upc_o      (upc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [5:0]  upc;
        logic [14:0] ctrl;
    } obs_t;

    obs_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    wire  [14:0] ctrl_bus = {alu_op, ld_r_out, ld_r_in, sel_r_in, ld_rf, fld_c, fld_b, fld_a};

    function automatic logic [14:0] ctl(input logic [1:0] alu, input logic lro, input logic lri,
                                        input logic sri, input logic lrf, input logic [2:0] c,
                                        input logic [2:0] b, input logic [2:0] a);
        return {alu, lro, lri, sri, lrf, c, b, a};
    endfunction

    function automatic logic [23:0] uw(input logic [5:0] nxt, input cond_e cond,
                                       input logic [14:0] c);
        return {nxt, cond, c};
    endfunction

    // Monitor
    obs_t act, expv;
    always @(negedge clk) begin
        if (busy || done) begin
            act = {busy, done, err, upc, ctrl_bus};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got busy=%0b done=%0b upc=%0d ctrl=%h, required none",
                         busy, done, upc, ctrl_bus);
            end else begin
                expv = exp_q.pop_front();
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL trace: got busy=%0b done=%0b err=%0b upc=%0d ctrl=%h, required busy=%0b done=%0b err=%0b upc=%0d ctrl=%h",
                             act.busy, act.done, act.err, act.upc, act.ctrl,
                             expv.busy, expv.done, expv.err, expv.upc, expv.ctrl);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic exp_run(input logic [5:0] a, input logic [23:0] w);
        exp_q.push_back({1'b1, 1'b0, 1'b0, a, w[14:0]});
    endtask

    task automatic exp_done(input logic [5:0] a);
        exp_q.push_back({1'b0, 1'b1, 1'b0, a, 15'd0});
    endtask

    task automatic wr(input logic [5:0] a, input logic [23:0] d);
        uc_we    = 1'b1;
        uc_waddr = a;
        uc_wdata = d;
        tick();
        uc_we    = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d expected outputs still pending, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_idle_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    typedef struct {
        cond_e      cond;
        logic       z, n, c;
        logic [5:0] tgt;
    } br_t;

    br_t br_tab[10] = '{
        '{CondJz,  1'b1, 1'b0, 1'b0, 6'd9},
        '{CondJz,  1'b0, 1'b1, 1'b1, 6'd4},
        '{CondJnz, 1'b0, 1'b0, 1'b0, 6'd9},
        '{CondJnz, 1'b1, 1'b0, 1'b0, 6'd4},
        '{CondJn,  1'b0, 1'b1, 1'b0, 6'd9},
        '{CondJn,  1'b1, 1'b0, 1'b1, 6'd4},
        '{CondJc,  1'b0, 1'b0, 1'b1, 6'd9},
        '{CondJc,  1'b1, 1'b1, 1'b0, 6'd4},
        '{CondJmp, 1'b0, 1'b0, 1'b0, 6'd9},
        '{CondRsv, 1'b1, 1'b1, 1'b1, 6'd4}
    };

    logic [23:0] w0, w1, w2, b2, b3, b4, b9, wnew, wj, w63, w5, wlast;

    initial begin
        rst = 1'b1; start = 1'b0; uc_we = 1'b0; uc_waddr = '0; uc_wdata = '0;
        cy = 1'b0; neg = 1'b0; zero = 1'b0;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err",  {31'd0, err},  32'd0);
        check("reset_upc",  {26'd0, upc},  32'd0);
        check("reset_ctrl", {17'd0, ctrl_bus}, 32'd0);
        rst = 1'b0;
        tick();

        // Straight-line program
        w0 = uw(6'd0, CondSeq,  ctl(AluAdd, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0));
        w1 = uw(6'd0, CondSeq,  ctl(AluAdd, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 3'd0));
        w2 = uw(6'd0, CondHalt, ctl(AluAdd, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd1));
        wr(6'd0, w0);
        wr(6'd1, w1);
        wr(6'd2, w2);
        exp_run(6'd0, w0); exp_run(6'd1, w1); exp_run(6'd2, w2); exp_done(6'd2);
        go();
        drain("straight");

        // Reset for two cycles mid-RUN
        exp_run(6'd0, w0);
        go();
        rst = 1'b1;
        tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err",  {31'd0, err},  32'd0);
        check("midrst_upc",  {26'd0, upc},  32'd0);
        check("midrst_ctrl", {17'd0, ctrl_bus}, 32'd0);
        tick();
        rst = 1'b0;
        exp_run(6'd0, w0); exp_run(6'd1, w1); exp_run(6'd2, w2); exp_done(6'd2);
        go();
        drain("rerun");

        // Branch conditions in both polarities
        b2 = uw(6'd0, CondSeq,  ctl(AluInc, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 3'd1));
        b4 = uw(6'd0, CondHalt, ctl(AluAdd, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 3'd0));
        b9 = uw(6'd0, CondHalt, ctl(AluAdd, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0, 3'd0));
        wr(6'd0, w0);
        wr(6'd1, w1);
        wr(6'd2, b2);
        wr(6'd4, b4);
        wr(6'd9, b9);
        for (int i = 0; i < 10; i++) begin
            b3 = uw(6'd9, br_tab[i].cond, ctl(AluSub, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 3'd3));
            wr(6'd3, b3);
            zero = br_tab[i].z;
            neg  = br_tab[i].n;
            cy   = br_tab[i].c;
            exp_run(6'd0, w0); exp_run(6'd1, w1); exp_run(6'd2, b2); exp_run(6'd3, b3);
            exp_run(br_tab[i].tgt, (br_tab[i].tgt == 6'd9) ? b9 : b4);
            exp_done(br_tab[i].tgt);
            go();
            drain("branch");
        end
        zero = 1'b0; neg = 1'b0; cy = 1'b0;

        // Write to START_ADDR in the same IDLE cycle as start
        wnew = uw(6'd0, CondHalt, ctl(AluSub, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd3, 3'd6));
        exp_run(6'd0, wnew); exp_done(6'd0);
        uc_we = 1'b1; uc_waddr = 6'd0; uc_wdata = wnew; start = 1'b1;
        tick();
        uc_we = 1'b0; start = 1'b0;
        drain("wr_start");

        // Watchdog abort, upc wrap 63->0, write-protect during RUN
        w5  = uw(6'd0,  CondHalt, ctl(AluAdd, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 3'd0));
        wj  = uw(6'd63, CondJmp,  ctl(AluAdd, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd2));
        w63 = uw(6'd17, CondSeq,  ctl(AluAdd, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 3'd0));
        wr(6'd5, w5);
        wr(6'd0, wj);
        wr(6'd63, w63);
        for (int i = 0; i < 4; i++) begin
            exp_run(6'd0, wj);
            exp_run(6'd63, w63);
        end
        go();
        wr(6'd5, 24'hFFFFFF);
        drain("wdog");
        check("wdog_err", {31'd0, err}, 32'd1);

        // Fresh start clears err; store[5] must still hold w5
        wlast = uw(6'd5, CondJmp, ctl(AluInc, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd4));
        wr(6'd0, wlast);
        check("err_held_idle", {31'd0, err}, 32'd1);
        exp_run(6'd0, wlast); exp_run(6'd5, w5); exp_done(6'd5);
        go();
        drain("after_wdog");
        check("err_cleared", {31'd0, err}, 32'd0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required $finish before limit");
        $fatal(1, "bench timeout");
    end

endmodule
